reaction_timer: RTL
===================

// Module: reaction_timer
// PURPOSE
//  Driver-side counterpart of the F1 start-light sequence: measures the time from
//  lights-out to the driver's button press, in milliseconds, as 4-digit BCD.
//  Consumes the sequencer's "sequence running" level and "lights out" pulse plus the
//  raw push-button; drives the 7-seg digit decoders and the status LEDs.
//  Also flags false starts, flags no-response timeouts and holds a best-time record.
// PARAMETERS
//  SYNC_STAGES  2     flip-flop stages on press input (>=2)
//  MAX_MS       9999  timeout / saturation value in ms (1..9999)
// PORTS
//  clk          in   1   system clock (same domain as sequencer)
//  rst          in   1   asynchronous, active-high reset
//  tick_ms      in   1   1-cycle enable, once per millisecond
//  seq_active   in   1   high while the light sequence and random delay run
//  lights_out   in   1   1-cycle pulse when all lights extinguish
//  press        in   1   raw button, active-high (already inverted), asynchronous
//  clear_best   in   1   1-cycle pulse: reset best-time record
//  bcd0..bcd3   out  4   each; current reaction time, ones..thousands ms
//  best0..best3 out  4   each; best valid reaction time, ones..thousands ms
//  valid        out  1   reaction time in bcd* is a completed measurement
//  false_start  out  1   press detected before lights_out
//  no_response  out  1   MAX_MS elapsed without press
//  busy         out  1   state is ARMED or TIMING
// BEHAVIOUR
//  Reset (async): state IDLE; bcd*=0; best*=9,9,9,9; all flags 0.
//  press -> SYNC_STAGES FF synchroniser -> rising-edge detect (press_rise, 1 cycle).
//   Latency raw press to press_rise: SYNC_STAGES+1 clk. Button held => one edge only.
//  seq_rise = rising edge of seq_active (registered previous value).
//  Counter: 4-digit cascaded BCD decade counter, each digit 0..9, carry on 9->0.
//   Increments only on tick_ms in TIMING; never passes MAX_MS.
//  States:
//   IDLE    : seq_rise -> ARMED.
//   ARMED   : on entry bcd*=0, valid/false_start/no_response=0.
//             press_rise -> FALSE (false_start=1, bcd* stay 0).
//             else lights_out -> TIMING (bcd*=0).
//             press_rise and lights_out same cycle -> FALSE (press wins).
//   TIMING  : tick_ms -> count+1. press_rise -> DONE, valid=1, bcd* frozen at the
//             value held that cycle (coincident tick_ms NOT applied).
//             count==MAX_MS and tick_ms -> TIMEOUT, no_response=1, valid=0.
//   DONE    : if valid time < best (BCD magnitude compare, digit 3 first) best*=bcd*
//             in the cycle after entry; equal does not update.
//   DONE/FALSE/TIMEOUT: outputs held; further presses ignored; seq_rise -> ARMED.
//  seq_rise in ARMED or TIMING (sequence restarted) -> ARMED, measurement discarded.
//  lights_out outside ARMED ignored. press_rise in IDLE ignored.
//  clear_best: best*=9,9,9,9 next cycle in any state; takes priority over a
//   same-cycle best update.
//  No-response and false-start results never update best*.
//  rst asserted mid-measurement: immediate return to reset values, incl. best*.
//  busy is a combinational decode of the state register.
// TESTING  (bench: tick_ms every 4 clk)
//  1 seq_active 1, lights_out, press after 237 ticks -> bcd=0,2,3,7 valid=1, best=0237
//  2 second run, press after 412 ticks -> bcd=0412 valid=1, best stays 0237;
//    third run 0150 -> best=0150; clear_best -> best=9999
//  3 press during ARMED, then lights_out -> false_start=1, valid=0, bcd=0000, no TIMING
//  4 press_rise and lights_out same cycle -> false_start=1; held press over later
//    lights_out gives no new edge
//  5 MAX_MS=20, no press -> bcd=0020, no_response=1, valid=0, best unchanged;
//    count 0009->0010 and 0099->0100 carries checked at MAX_MS=9999
//  6 rst pulse mid-TIMING at 0055 -> all outputs at reset values immediately,
//    IDLE; new seq_rise starts a clean run

Source files
------------

// File: rtl/reaction_timer.sv
// reaction_timer
//   Measures the time from the start-light "lights out" pulse to the driver's
//   button press, in milliseconds, as a 4-digit BCD value. It flags false
//   starts (press before lights out) and no-response timeouts (MAX_MS elapsed).
//   It also keeps a best-time record that only valid measurements can lower.
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   tick_ms         1-cycle enable once per millisecond
//   seq_active      level, high while the light sequence / random delay runs
//   lights_out      1-cycle pulse when all lights extinguish
//   press           raw asynchronous push-button, active-high
//   clear_best      1-cycle pulse, resets best record to 9999
//   bcd0..bcd3      current reaction time, ones..thousands
//   best0..best3    best valid reaction time, ones..thousands
//   valid           bcd* holds a completed measurement
//   false_start     press seen before lights out
//   no_response     MAX_MS elapsed without a press
//   busy            ARMED or TIMING
module reaction_timer #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MS      = 9999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       seq_active,
  input  logic       lights_out,
  input  logic       press,
  input  logic       clear_best,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] best0,
  output logic [3:0] best1,
  output logic [3:0] best2,
  output logic [3:0] best3,
  output logic       valid,
  output logic       false_start,
  output logic       no_response,
  output logic       busy
);

  localparam logic [15:0] MAX_BCD = {4'((MAX_MS / 1000) % 10), 4'((MAX_MS / 100) % 10),
                                     4'((MAX_MS / 10) % 10),   4'(MAX_MS % 10)};
  localparam logic [15:0] BEST_INIT = 16'h9999;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_TIMING, S_DONE, S_FALSE, S_TIMEOUT
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   press_q;
  logic                   press_rise;
  logic                   seq_q;
  logic                   seq_rise;
  logic [15:0]            cnt;
  logic [15:0]            best;
  logic                   done_entry;

  // Cascaded decade increment: each digit wraps 9->0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Button synchroniser and edge detect; a held button yields a single edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      press_q <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], press};
      press_q <= sync_q[SYNC_STAGES-1];
      seq_q   <= seq_active;
    end
  end

  assign press_rise = sync_q[SYNC_STAGES-1] & ~press_q;
  assign seq_rise   = seq_active & ~seq_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A sequence restart re-arms from every state, which also
  // discards any measurement in progress.
  always_comb begin
    state_nxt = state;
    if (seq_rise) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          if (press_rise)      state_nxt = S_FALSE;   // press beats lights_out
          else if (lights_out) state_nxt = S_TIMING;
        end
        S_TIMING: begin
          if (press_rise)                       state_nxt = S_DONE;
          else if (tick_ms && cnt == MAX_BCD)   state_nxt = S_TIMEOUT;
        end
        S_IDLE, S_DONE, S_FALSE, S_TIMEOUT: state_nxt = state;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy = (state == S_ARMED) || (state == S_TIMING);
  end

  // Measurement datapath. A press wins over a coincident tick so the frozen
  // value is the one displayed when the press was seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      valid       <= 1'b0;
      false_start <= 1'b0;
      no_response <= 1'b0;
      done_entry  <= 1'b0;
    end else begin
      done_entry <= 1'b0;
      if (seq_rise) begin
        cnt         <= '0;
        valid       <= 1'b0;
        false_start <= 1'b0;
        no_response <= 1'b0;
      end else if (state == S_ARMED) begin
        if (press_rise) false_start <= 1'b1;
      end else if (state == S_TIMING) begin
        if (press_rise) begin
          valid      <= 1'b1;
          done_entry <= 1'b1;
        end else if (tick_ms) begin
          if (cnt == MAX_BCD) no_response <= 1'b1;
          else                cnt         <= bcd_inc(cnt);
        end
      end
    end
  end

  // Best record. Packed BCD compares correctly as an unsigned vector since
  // digit 3 is the most significant nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            best <= BEST_INIT;
    else if (clear_best)                best <= BEST_INIT;
    else if (done_entry && cnt < best)  best <= cnt;
  end

  assign {bcd3, bcd2, bcd1, bcd0}     = cnt;
  assign {best3, best2, best1, best0} = best;

endmodule
